// File: rtl/pll_lock_supervisor_pkg.sv
// pll_sup_pkg: state encoding, counter sizing and parameter checks for the PLL lock supervisor.
package pll_sup_pkg;

   typedef enum logic [1:0] {
      PLL_RESET = 2'd0,
      WAIT_LOCK = 2'd1,
      STABILIZE = 2'd2,
      RUNNING   = 2'd3
   } sup_state_t;

   // One shared dwell counter must reach the largest of the three cycle limits.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

   function automatic bit params_ok(input int rp, input int sc, input int tc, input int cw);
      return (rp >= 2) && (sc >= 2) && (tc >= 2) && (cw >= 1);
   endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// pll_lock_supervisor_if: PLL status/control and system reset signals between supervisor and its environment.
interface pll_lock_supervisor_if #(parameter int CNT_W = 8);

   logic             pll_locked;
   logic             force_relock;
   logic             pll_rst;
   logic             sys_rst;
   logic             ready;
   logic [1:0]       sup_state;
   logic             lock_lost;
   logic [CNT_W-1:0] relock_count;
   logic [CNT_W-1:0] timeout_count;

   modport master (
      input  pll_locked, force_relock,
      output pll_rst, sys_rst, ready, sup_state, lock_lost, relock_count, timeout_count
   );

   modport slave (
      output pll_locked, force_relock,
      input  pll_rst, sys_rst, ready, sup_state, lock_lost, relock_count, timeout_count
   );

endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous status bit, resets to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or posedge rst)
      if (rst) {r_sync, r_meta} <= 2'b00;
      else     {r_sync, r_meta} <= {r_meta, i_d};

   assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: holds the PLL in reset, waits for stable lock, then releases the system reset;
// restarts the PLL on lock loss, lock timeout or software request.
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int RST_PULSE_CYCLES = 16,
   parameter int STABLE_CYCLES    = 4096,
   parameter int TIMEOUT_CYCLES   = 1000000,
   parameter int CNT_W            = 8
) (
   input  logic                  refclk,
   input  logic                  rst,
   pll_lock_supervisor_if.master bus
);

   localparam int DW = cnt_width(RST_PULSE_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES);

   if (!params_ok(RST_PULSE_CYCLES, STABLE_CYCLES, TIMEOUT_CYCLES, CNT_W)) begin : g_param_err
      $error("pll_lock_supervisor: cycle parameters must be >= 2 and CNT_W >= 1");
   end

   sup_state_t       r_state;
   sup_state_t       w_nxt;
   logic [DW-1:0]    r_cnt;
   logic [CNT_W-1:0] r_relock;
   logic [CNT_W-1:0] r_tmo;
   logic             r_pll_rst;
   logic             r_sys_rst;
   logic             r_ready;
   logic             r_lost;
   logic             w_locked_s;
   logic             w_clr;
   logic             w_lost;
   logic             w_tmo;

   sync_2ff u_sync (
      .clk (refclk),
      .rst (rst),
      .i_d (bus.pll_locked),
      .o_q (w_locked_s)
   );

   always_comb begin
      w_nxt  = r_state;
      w_clr  = 1'b0;
      w_lost = 1'b0;
      w_tmo  = 1'b0;
      case (r_state)
         PLL_RESET: begin
            // A relock request while already resetting stretches the pulse.
            w_clr = bus.force_relock;
            if (!bus.force_relock && r_cnt == DW'(RST_PULSE_CYCLES - 1)) w_nxt = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (bus.force_relock) w_nxt = PLL_RESET;
            else if (w_locked_s) w_nxt = STABILIZE;
            else if (r_cnt == DW'(TIMEOUT_CYCLES - 1)) begin
               w_nxt = PLL_RESET;
               w_tmo = 1'b1;
            end
         end
         STABILIZE: begin
            if (bus.force_relock) w_nxt = PLL_RESET;
            else if (!w_locked_s) w_nxt = WAIT_LOCK;
            else if (r_cnt == DW'(STABLE_CYCLES - 1)) w_nxt = RUNNING;
         end
         RUNNING: begin
            w_lost = !w_locked_s;
            if (!w_locked_s || bus.force_relock) w_nxt = PLL_RESET;
         end
         default: w_nxt = PLL_RESET;
      endcase
   end

   always_ff @(posedge refclk or posedge rst)
      if (rst) begin
         r_state   <= PLL_RESET;
         r_cnt     <= '0;
         r_pll_rst <= 1'b1;
         r_sys_rst <= 1'b1;
         r_ready   <= 1'b0;
         r_lost    <= 1'b0;
         r_relock  <= '0;
         r_tmo     <= '0;
      end else begin
         r_state   <= w_nxt;
         r_cnt     <= (w_clr || w_nxt != r_state) ? '0 : r_cnt + 1'b1;
         r_pll_rst <= w_nxt == PLL_RESET;
         r_sys_rst <= w_nxt != RUNNING;
         r_ready   <= w_nxt == RUNNING;
         r_lost    <= w_lost;
         if (w_lost && r_relock != '1) r_relock <= r_relock + 1'b1;
         if (w_tmo && r_tmo != '1) r_tmo <= r_tmo + 1'b1;
      end

   assign bus.pll_rst       = r_pll_rst;
   assign bus.sys_rst       = r_sys_rst;
   assign bus.ready         = r_ready;
   assign bus.sup_state     = r_state;
   assign bus.lock_lost     = r_lost;
   assign bus.relock_count  = r_relock;
   assign bus.timeout_count = r_tmo;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: directed vectors with hand-derived cycle counts for the PLL lock supervisor.
module tb_pll_lock_supervisor;

   logic refclk = 1'b0;
   logic rst    = 1'b1;
   int   n_tot  = 0;
   int   n_bad  = 0;

   pll_lock_supervisor_if #(.CNT_W(4)) bus ();

   pll_lock_supervisor #(
      .RST_PULSE_CYCLES (4),
      .STABLE_CYCLES    (8),
      .TIMEOUT_CYCLES   (32),
      .CNT_W            (4)
   ) dut (
      .refclk (refclk),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 refclk = ~refclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic wait_state(input logic [1:0] s, input int lim);
      int n;
      n = 0;
      while (bus.sup_state !== s && n < lim) begin
         step(1);
         n++;
      end
      check("wait_state", bus.sup_state, s);
   endtask

   initial begin
      bus.pll_locked   = 1'b1;
      bus.force_relock = 1'b0;
      #12;
      check("rst_state", bus.sup_state, 0);
      check("rst_pll_rst", bus.pll_rst, 1);
      check("rst_sys_rst", bus.sys_rst, 1);
      check("rst_ready", bus.ready, 0);
      check("rst_lock_lost", bus.lock_lost, 0);
      check("rst_relock", bus.relock_count, 0);
      check("rst_timeout", bus.timeout_count, 0);
      @(posedge refclk);
      #1 rst = 1'b0;
      // cold start: 4 cycles of pll_rst, 1 in WAIT_LOCK, 8 in STABILIZE
      step(3);
      check("cold_e3_state", bus.sup_state, 0);
      check("cold_e3_pll_rst", bus.pll_rst, 1);
      step(1);
      check("cold_e4_state", bus.sup_state, 1);
      check("cold_e4_pll_rst", bus.pll_rst, 0);
      check("cold_e4_sys_rst", bus.sys_rst, 1);
      step(1);
      check("cold_e5_state", bus.sup_state, 2);
      step(7);
      check("cold_e12_state", bus.sup_state, 2);
      check("cold_e12_sys_rst", bus.sys_rst, 1);
      check("cold_e12_ready", bus.ready, 0);
      step(1);
      check("cold_e13_state", bus.sup_state, 3);
      check("cold_e13_ready", bus.ready, 1);
      check("cold_e13_sys_rst", bus.sys_rst, 0);
      check("cold_e13_pll_rst", bus.pll_rst, 0);
      // one-cycle lock drop in RUNNING
      bus.pll_locked = 1'b0;
      step(1);
      bus.pll_locked = 1'b1;
      step(1);
      check("drop_e2_state", bus.sup_state, 3);
      check("drop_e2_lost", bus.lock_lost, 0);
      step(1);
      check("drop_e3_state", bus.sup_state, 0);
      check("drop_e3_lost", bus.lock_lost, 1);
      check("drop_e3_relock", bus.relock_count, 1);
      check("drop_e3_pll_rst", bus.pll_rst, 1);
      check("drop_e3_sys_rst", bus.sys_rst, 1);
      step(1);
      check("drop_e4_lost", bus.lock_lost, 0);
      step(2);
      check("drop_e6_state", bus.sup_state, 0);
      step(1);
      check("drop_e7_state", bus.sup_state, 1);
      step(1);
      check("drop_e8_state", bus.sup_state, 2);
      step(8);
      check("drop_e16_state", bus.sup_state, 3);
      check("drop_e16_ready", bus.ready, 1);
      // force_relock alone, then a lock glitch during STABILIZE
      bus.force_relock = 1'b1;
      step(1);
      bus.force_relock = 1'b0;
      check("force_state", bus.sup_state, 0);
      check("force_relock_cnt", bus.relock_count, 1);
      check("force_lost", bus.lock_lost, 0);
      check("force_timeout", bus.timeout_count, 0);
      step(4);
      check("glitch_f4_state", bus.sup_state, 1);
      step(1);
      check("glitch_f5_state", bus.sup_state, 2);
      step(4);
      bus.pll_locked = 1'b0;
      step(1);
      bus.pll_locked = 1'b1;
      step(1);
      check("glitch_f11_state", bus.sup_state, 2);
      step(1);
      check("glitch_f12_state", bus.sup_state, 1);
      check("glitch_f12_sys_rst", bus.sys_rst, 1);
      step(1);
      check("glitch_f13_state", bus.sup_state, 2);
      step(7);
      check("glitch_f20_state", bus.sup_state, 2);
      check("glitch_f20_sys_rst", bus.sys_rst, 1);
      step(1);
      check("glitch_f21_state", bus.sup_state, 3);
      check("glitch_f21_sys_rst", bus.sys_rst, 0);
      // force_relock together with lock loss, then repeated requests in PLL_RESET
      bus.pll_locked = 1'b0;
      step(1);
      bus.pll_locked = 1'b1;
      step(1);
      bus.force_relock = 1'b1;
      step(1);
      bus.force_relock = 1'b0;
      check("both_state", bus.sup_state, 0);
      check("both_lost", bus.lock_lost, 1);
      check("both_relock", bus.relock_count, 2);
      bus.force_relock = 1'b1;
      step(1);
      bus.force_relock = 1'b0;
      step(1);
      bus.force_relock = 1'b1;
      step(1);
      bus.force_relock = 1'b0;
      step(3);
      check("stretch_g9_state", bus.sup_state, 0);
      check("stretch_g9_pll_rst", bus.pll_rst, 1);
      step(1);
      check("stretch_g10_state", bus.sup_state, 1);
      check("stretch_g10_pll_rst", bus.pll_rst, 0);
      check("stretch_relock", bus.relock_count, 2);
      step(9);
      check("stretch_g19_state", bus.sup_state, 3);
      // PLL never locks: retry every 36 cycles
      bus.pll_locked = 1'b0;
      step(3);
      check("tmo_h3_state", bus.sup_state, 0);
      check("tmo_h3_relock", bus.relock_count, 3);
      step(4);
      check("tmo_h7_state", bus.sup_state, 1);
      step(31);
      check("tmo_h38_state", bus.sup_state, 1);
      check("tmo_h38_cnt", bus.timeout_count, 0);
      step(1);
      check("tmo_h39_state", bus.sup_state, 0);
      check("tmo_h39_pll_rst", bus.pll_rst, 1);
      check("tmo_h39_cnt", bus.timeout_count, 1);
      step(35);
      check("tmo_h74_state", bus.sup_state, 1);
      step(1);
      check("tmo_h75_state", bus.sup_state, 0);
      check("tmo_h75_cnt", bus.timeout_count, 2);
      step(36);
      check("tmo_h111_state", bus.sup_state, 0);
      check("tmo_h111_cnt", bus.timeout_count, 3);
      // drive the relock counter to saturation (20 losses total)
      bus.pll_locked = 1'b1;
      for (int i = 0; i < 17; i++) begin
         wait_state(2'd3, 100);
         bus.pll_locked = 1'b0;
         step(1);
         bus.pll_locked = 1'b1;
         step(2);
         check("sat_lost", bus.lock_lost, 1);
      end
      check("sat_relock", bus.relock_count, 15);
      check("sat_timeout", bus.timeout_count, 3);
      // asynchronous reset in the middle of STABILIZE
      wait_state(2'd2, 100);
      step(3);
      #2 rst = 1'b1;
      #1;
      check("arst_state", bus.sup_state, 0);
      check("arst_pll_rst", bus.pll_rst, 1);
      check("arst_sys_rst", bus.sys_rst, 1);
      check("arst_ready", bus.ready, 0);
      check("arst_relock", bus.relock_count, 0);
      check("arst_timeout", bus.timeout_count, 0);
      #20 rst = 1'b0;
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Consumer side of the system PLL. Watches the PLL's asynchronous `locked` output, drives the PLL's reset input, and generates the downstream system reset.
- Lock must be stable for a programmable time before the system is released. Loss of lock, or a software relock request, restarts the PLL.
- A PLL that fails to lock is retried after a timeout.
- Clocked by the PLL's reference clock, so it keeps running while the PLL is unlocked.

Parameters:
- RST_PULSE_CYCLES, 16: width of the pll_rst assertion in refclk cycles; must be >= 2.
- STABLE_CYCLES, 4096: consecutive synchronized-locked cycles required before release; must be >= 2.
- TIMEOUT_CYCLES, 1000000: maximum WAIT_LOCK dwell before retrying the PLL reset (20 ms at 50 MHz); must be >= 2.
- CNT_W, 8: width of the event counters.

Ports:
- refclk  in  1  only clock (PLL reference clock).
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL locked output; asynchronous to refclk.
- force_relock  in  1  refclk-synchronous single-cycle request, e.g. after a frequency change.
- pll_rst  out  1  reset to the PLL, active-high.
- sys_rst  out  1  reset for logic on PLL output clocks, active-high.
- ready  out  1  high only in RUNNING.
- sup_state  out  2  current state encoding.
- lock_lost  out  1  one-cycle pulse on loss of lock while RUNNING.
- relock_count  out  CNT_W  saturating count of lock losses in RUNNING.
- timeout_count  out  CNT_W  saturating count of WAIT_LOCK timeouts.

Behaviour:
- Interface: one clock, refclk; reset rst is asynchronous, active-high.
- Reset values:
  - state PLL_RESET, pll_rst=1, sys_rst=1, ready=0, lock_lost=0.
  - Both event counters 0; dwell counter 0; synchronizer flops 0.
- Synchronizer: pll_locked passes through a 2-flop synchronizer to give locked_s (2-cycle latency). All decisions use locked_s only.
- Dwell counter: one shared counter, width $clog2 of the largest of the three cycle parameters. It clears on every state transition.
- Output timing: all outputs are registered and decoded from next-state, so they change in the same cycle as sup_state.
- States and transitions (encoding PLL_RESET=0, WAIT_LOCK=1, STABILIZE=2, RUNNING=3):
  - PLL_RESET: pll_rst=1, sys_rst=1. When count == RST_PULSE_CYCLES-1, go to WAIT_LOCK.
  - WAIT_LOCK: pll_rst=0, sys_rst=1.
    - If locked_s, go to STABILIZE.
    - Else if count == TIMEOUT_CYCLES-1, go to PLL_RESET and increment timeout_count.
  - STABILIZE: pll_rst=0, sys_rst=1.
    - If !locked_s, go to WAIT_LOCK (timeout window restarts).
    - Else if count == STABLE_CYCLES-1, go to RUNNING.
  - RUNNING: pll_rst=0, sys_rst=0, ready=1.
    - If !locked_s, go to PLL_RESET, pulse lock_lost for 1 cycle, and increment relock_count.
- force_relock:
  - In WAIT_LOCK, STABILIZE or RUNNING: go to PLL_RESET next cycle. No counter increments.
  - In PLL_RESET: restarts the pulse count from 0.
- Simultaneous force_relock and !locked_s in RUNNING: go to PLL_RESET, and the lock loss is still counted and pulsed.
- Event counters saturate at 2^CNT_W-1 and clear only on rst.
- rst asserted mid-operation: immediate return to reset values. pll_rst=1 and sys_rst=1 asynchronously.
- Glitch filtering: a locked_s glitch shorter than STABLE_CYCLES in STABILIZE never releases sys_rst.

Decomposition:
- Package pll_sup_pkg:
  - state enum sup_state_t (2 bits, encodings above).
  - Function for counter width.
  - Elaboration-time parameter range checks.
- Sub-module sync_2ff: single-bit 2-flop synchronizer with asynchronous reset to 0; reused for other async status inputs.

Test Plan:
Bench parameters: RST_PULSE_CYCLES=4, STABLE_CYCLES=8, TIMEOUT_CYCLES=32, CNT_W=4.
- Cold start, pll_locked=1 throughout, rst released:
  - pll_rst high for exactly 4 cycles.
  - WAIT_LOCK for 1 cycle, then STABILIZE for 8 cycles.
  - ready=1 and sys_rst=0 at edge 13 after release.
- pll_locked held 0: pll_rst re-pulses every 36 cycles (4+32), and timeout_count reads 1, 2, 3 after each retry.
- Lock drop in RUNNING (pll_locked=0 for 1 cycle):
  - lock_lost pulses once, 2-3 cycles later.
  - relock_count becomes 1; sys_rst=1 and pll_rst=1 for 4 cycles.
  - Re-release after the full sequence.
- Glitch in STABILIZE: pll_locked low for 1 cycle at stabilize count 5 → state returns to WAIT_LOCK and sys_rst stays 1; release occurs 8+ cycles after lock returns.
- Simultaneous force_relock and lock loss in RUNNING:
  - PLL_RESET entered, lock_lost=1, relock_count increments by 1 only.
  - force_relock alone: no count change.
  - force_relock repeated in PLL_RESET extends pll_rst to 4 cycles after the last request.
- Saturation and reset:
  - 20 induced lock losses → relock_count = 15.
  - Async rst mid-STABILIZE → pll_rst=1, sys_rst=1 and counters 0 without a refclk edge.
